// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit, 4-register MIPS-style datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB steps over a shared ALU and unified memory port.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_source,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MEM_TIMEOUT);
  localparam bit TimeoutEn = (MEM_TIMEOUT != 0);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StTrap     = 4'd11
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q;
  logic               illegal_q, bus_error_q;
  logic [CNT_W-1:0]   count_q;

  logic in_mem_state;
  logic limit_hit;
  logic retire;
  logic set_illegal;
  logic set_timeout;

  assign in_mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign limit_hit    = TimeoutEn && (wait_q == WaitLimit) && !mem_ready;

  // Next-state and event decode.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (limit_hit) begin
          state_d     = StTrap;
          set_timeout = 1'b1;
        end
      end
      StDecode: begin
        case (op)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: state_d = StRExec;
          4'b0100:                                     state_d = StAddiExec;
          4'b0101, 4'b0110:                            state_d = StMemAddr;
          4'b1000:                                     state_d = StBranch;
          default: begin
            state_d     = StTrap;
            set_illegal = 1'b1;
          end
        endcase
      end
      StMemAddr:  state_d = (op == 4'b0110) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (limit_hit) begin
          state_d     = StTrap;
          set_timeout = 1'b1;
        end
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (limit_hit) begin
          state_d     = StTrap;
          set_timeout = 1'b1;
        end
      end
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      StMemWb, StRWb, StAddiWb, StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StFetch;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) bus_error_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
      // Counter restarts on every state change, so each memory state gets a fresh budget.
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (TimeoutEn && in_mem_state && !mem_ready) begin
        wait_q <= wait_q + WaitW'(1);
      end
    end
  end

  // Moore output decode; memory-state strobes are qualified by mem_ready.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: alu_src_b = 2'b11;
      StMemAddr, StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 1'b1;
        pc_write  = zero;
      end
      StAddiWb: reg_write = 1'b1;
      default: ;
    endcase
    // Reset drops any outstanding access in the same cycle.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign bus_error   = bus_error_q;
  assign instr_count = count_q;

  a_no_rw_with_mem : assert property (@(posedge clock) disable iff (reset)
    !(reg_write && mem_req));

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-path model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_multicycle_control;

  localparam int unsigned MemTimeout = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  op = 4'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, iord, ir_write, pc_write, pc_source;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic [3:0]  state;
  logic        illegal_op, bus_error;
  logic [15:0] instr_count;

  multicycle_control #(.MEM_TIMEOUT(MemTimeout), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .illegal_op(illegal_op), .bus_error(bus_error), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       mem_req, mem_write, iord, ir_write, pc_write, pc_source;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
  } ctl_t;

  // Control word required in each step of an instruction.
  function automatic ctl_t expected_ctl(input int s, input logic rdy, input logic z);
    ctl_t c = '0;
    case (s)
      0:  begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_req = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_req = 1; c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 1; c.pc_write = z; end
      9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      10: c.reg_write = 1;
      default: ;
    endcase
    return c;
  endfunction

  // Model: each instruction is a fixed list of steps chosen at decode.
  int          m_path[5];
  int          m_len;
  int          m_idx;
  int          m_wait;
  bit          m_trap, m_ill, m_bus, m_valid;
  logic [15:0] m_cnt;
  int          cur;
  ctl_t        e_ctl, a_ctl;

  task automatic set_path(input int a, b, c, d, f, input int len);
    m_path[0] = a; m_path[1] = b; m_path[2] = c; m_path[3] = d; m_path[4] = f;
    m_len = len;
  endtask

  initial m_valid = 1'b0;

  always @(negedge clock) begin
    #3;
    if (reset === 1'b1) begin
      chk("rst_strobes", 32'({mem_req, ir_write, pc_write, reg_write}), 32'd0);
      set_path(0, 1, 0, 0, 0, 2);
      m_idx = 0; m_wait = 0; m_trap = 0; m_ill = 0; m_bus = 0; m_cnt = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      cur   = m_trap ? 11 : m_path[m_idx];
      e_ctl = expected_ctl(cur, mem_ready, zero);
      a_ctl = {mem_req, mem_write, iord, ir_write, pc_write, pc_source,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};
      if (!e_ctl.mem_req) a_ctl.mem_write = e_ctl.mem_write;
      chk("ctl", 32'(a_ctl), 32'(e_ctl));
      chk("state", 32'(state), 32'(cur));
      chk("illegal_op", 32'(illegal_op), 32'(m_ill));
      chk("bus_error", 32'(bus_error), 32'(m_bus));
      chk("instr_count", 32'(instr_count), 32'(m_cnt));
      if (m_trap) begin
      end else if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) begin
        if (MemTimeout != 0 && m_wait == MemTimeout) begin
          m_trap = 1; m_bus = 1;
        end else begin
          m_wait++;
        end
      end else begin
        m_wait = 0;
        if (cur == 1) begin
          case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd7: set_path(0, 1, 6, 7, 0, 4);
            4'd4:                         set_path(0, 1, 9, 10, 0, 4);
            4'd5:                         set_path(0, 1, 2, 3, 4, 5);
            4'd6:                         set_path(0, 1, 2, 5, 0, 4);
            4'd8:                         set_path(0, 1, 8, 0, 0, 3);
            default: begin m_ill = 1; m_trap = 1; end
          endcase
        end
        if (!m_trap) begin
          m_idx++;
          if (m_idx == m_len) begin
            m_cnt++;
            m_idx = 0;
            set_path(0, 1, 0, 0, 0, 2);
          end
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [3:0] o, input logic z, input logic rdy);
    @(negedge clock);
    reset = r; op = o; zero = z; mem_ready = rdy;
    #1;
  endtask

  int addi_seq[8] = '{0, 1, 9, 10, 0, 1, 9, 10};
  int lw_seq[8]   = '{0, 1, 2, 3, 3, 3, 3, 4};

  initial begin
    drive(1, 4'h0, 0, 0);
    drive(1, 4'h0, 0, 0);

    // Two ADDIs, zero wait states.
    for (int k = 0; k < 8; k++) begin
      drive(0, 4'h4, 0, 1);
      if (k == 0) begin
        chk("reset_count", 32'(instr_count), 32'd0);
        chk("reset_illegal", 32'(illegal_op), 32'd0);
        chk("reset_bus", 32'(bus_error), 32'd0);
      end
      chk("addi_state", 32'(state), 32'(addi_seq[k]));
      chk("addi_reg_write", 32'(reg_write), 32'((k == 3) || (k == 7)));
    end

    // LW with three wait cycles in MEM_RD.
    for (int k = 0; k < 8; k++) begin
      drive(0, 4'h5, 0, (k >= 3 && k <= 5) ? 1'b0 : 1'b1);
      if (k == 0) chk("addi_count", 32'(instr_count), 32'd2);
      chk("lw_state", 32'(state), 32'(lw_seq[k]));
      if (k >= 3 && k <= 6) chk("lw_req_iord", 32'({mem_req, iord}), 32'h3);
      if (k == 7) chk("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
    end

    // BEQ taken, then not taken.
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'h8, 1, 1);
      if (k == 0) chk("lw_count", 32'(instr_count), 32'd3);
      if (k == 2) chk("beq_taken", 32'({state, pc_write, pc_source}), 32'h23);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'h8, 0, 1);
      if (k == 2) chk("beq_not_taken", 32'({state, pc_write, pc_source}), 32'h21);
    end

    // SW with one wait, then an R-type.
    for (int k = 0; k < 5; k++) begin
      drive(0, 4'h6, 0, (k == 3) ? 1'b0 : 1'b1);
      if (k == 0) chk("beq_count", 32'(instr_count), 32'd5);
    end
    for (int k = 0; k < 4; k++) drive(0, 4'h7, 0, 1);

    // Illegal opcode traps until reset.
    drive(0, 4'hF, 0, 1);
    chk("pre_trap_count", 32'(instr_count), 32'd7);
    drive(0, 4'hF, 0, 1);
    for (int k = 0; k < 20; k++) begin
      drive(0, 4'hF, 0, 1);
      chk("trap_state", 32'(state), 32'd11);
      chk("trap_flags", 32'({illegal_op, mem_req, ir_write, pc_write, reg_write}), 32'h10);
    end
    drive(1, 4'h4, 0, 0);

    // Fetch timeout: sixteen not-ready cycles trap.
    drive(0, 4'h4, 0, 0);
    chk("post_trap_state", 32'(state), 32'd0);
    chk("post_trap_illegal", 32'(illegal_op), 32'd0);
    for (int k = 1; k < 16; k++) drive(0, 4'h4, 0, 0);
    drive(0, 4'h4, 0, 0);
    chk("timeout_state", 32'(state), 32'd11);
    chk("timeout_bus_error", 32'(bus_error), 32'd1);
    drive(1, 4'h4, 0, 0);

    // Ready exactly on the limit cycle wins.
    for (int k = 0; k < 15; k++) drive(0, 4'h4, 0, 0);
    drive(0, 4'h4, 0, 1);
    drive(0, 4'h4, 0, 1);
    chk("limit_ready_state", 32'(state), 32'd1);
    chk("limit_ready_bus", 32'(bus_error), 32'd0);
    drive(0, 4'h4, 0, 1);
    drive(0, 4'h4, 0, 1);

    // Reset in the middle of a stalled store.
    drive(1, 4'h6, 0, 1);
    drive(0, 4'h6, 0, 1);
    drive(0, 4'h6, 0, 1);
    drive(0, 4'h6, 0, 1);
    drive(0, 4'h6, 0, 0);
    drive(0, 4'h6, 0, 0);
    chk("sw_wait_state", 32'(state), 32'd5);
    drive(1, 4'h6, 0, 1);
    chk("rst_mid_req", 32'({mem_req, ir_write, pc_write, reg_write}), 32'd0);
    drive(0, 4'h6, 0, 0);
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_count", 32'(instr_count), 32'd0);
    drive(0, 4'h6, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
